// File: rtl/ff2_sync_n_pkg.sv
// Shared constants for the multi-bit level synchronizer family.
package ff2_sync_n_pkg;

    // Default chain depth: two flops is the usual metastability margin.
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Fewer than two flops gives no settling time for a metastable first stage.
    localparam int SYNC_STAGES_MIN = 2;

endpackage : ff2_sync_n_pkg

// File: rtl/ff2_sync_bit.sv
// One bit of the level synchronizer: a plain chain of STAGES flops with no
// logic between them, loaded with RESET_VAL while rst is high.
module ff2_sync_bit
    import ff2_sync_n_pkg::*;
#(
    parameter int   STAGES    = SYNC_STAGES_DEFAULT,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // A chain shorter than the minimum offers no metastability protection.
    generate
        if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
            $error("ff2_sync_bit: STAGES must be at least %0d", SYNC_STAGES_MIN);
        end
    endgenerate

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the foreign-domain sample one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flops; reset discards anything still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : ff2_sync_bit

// File: rtl/ff2_sync_n.sv
// W independent level synchronizers with optional rise/fall pulse outputs.
// Define FF2_SYNC_N_EDGE_EN to build the edge detector; otherwise rise and
// fall are tied low and no history flops exist. Bits are not coherent with
// each other, so multi-bit inputs must be Gray coded.
module ff2_sync_n
    import ff2_sync_n_pkg::*;
#(
    parameter int         W         = 1,
    parameter int         STAGES    = SYNC_STAGES_DEFAULT,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    // Reject meaningless widths and unsafe chain depths at elaboration.
    generate
        if (W < 1 || STAGES < SYNC_STAGES_MIN) begin : g_bad_params
            $error("ff2_sync_n: need W >= 1 and STAGES >= %0d", SYNC_STAGES_MIN);
        end
    endgenerate

    // One independent flop chain per bit.
    for (genvar i = 0; i < W; i++) begin : g_bit
        ff2_sync_bit #(
            .STAGES    (STAGES),
            .RESET_VAL (RESET_VAL[i])
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (din[i]),
            .q   (dout[i])
        );
    end

`ifdef FF2_SYNC_N_EDGE_EN
    logic [W-1:0] hist_q;
    logic [W-1:0] hist_d;

    // History simply follows the synchronized output one cycle behind.
    always_comb begin
        hist_d = dout;
    end

    // History resets to the same value as the chain so reset never pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= RESET_VAL;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise = dout & ~hist_q;
    assign fall = ~dout & hist_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule : ff2_sync_n

// File: tb/tb_ff2_sync_n.sv
// Directed bench for ff2_sync_n: a W=1 instance driven from a vector table,
// a RESET_VAL=1 instance that must never pulse, and a W=4/STAGES=3 instance.
module tb_ff2_sync_n;

`ifdef FF2_SYNC_N_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       dinA;
    logic       doutA, riseA, fallA;
    logic       dinB;
    logic       doutB, riseB, fallB;
    logic [3:0] dinC;
    logic [3:0] doutC, riseC, fallC;

    int errors;
    int checks;

    typedef struct packed {
        logic rst;
        logic din;
        logic dout;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vecs [16];

    ff2_sync_n #(.W(1), .STAGES(2), .RESET_VAL(1'b0)) dutA (
        .clk (clk), .rst (rst), .din (dinA), .dout (doutA), .rise (riseA), .fall (fallA)
    );

    ff2_sync_n #(.W(1), .STAGES(2), .RESET_VAL(1'b1)) dutB (
        .clk (clk), .rst (rst), .din (dinB), .dout (doutB), .rise (riseB), .fall (fallB)
    );

    ff2_sync_n #(.W(4), .STAGES(3), .RESET_VAL(4'b0000)) dutC (
        .clk (clk), .rst (rst), .din (dinC), .dout (doutC), .rise (riseC), .fall (fallC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkA(input string name, input logic d, input logic r, input logic f);
        checkOutput({name, " doutA"}, {3'b0, doutA}, {3'b0, d});
        checkOutput({name, " riseA"}, {3'b0, riseA}, {3'b0, r & EDGE_ON});
        checkOutput({name, " fallA"}, {3'b0, fallA}, {3'b0, f & EDGE_ON});
    endtask

    task automatic checkB(input string name);
        checkOutput({name, " doutB"}, {3'b0, doutB}, 4'b0001);
        checkOutput({name, " riseB|fallB"}, {3'b0, riseB | fallB}, 4'b0000);
    endtask

    task automatic checkC(input string name, input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
        checkOutput({name, " doutC"}, doutC, d);
        checkOutput({name, " riseC"}, riseC, EDGE_ON ? r : 4'b0000);
        checkOutput({name, " fallC"}, fallC, EDGE_ON ? f : 4'b0000);
    endtask

    // Wait for the next rising edge and settle a little past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        dinA   = 1'b0;
        dinB   = 1'b1;
        dinC   = 4'b0000;

        //             rst   din   dout  rise  fall
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #1;
        checkA("reset-asserted", 1'b0, 1'b0, 1'b0);
        checkB("reset-asserted");
        checkC("reset-asserted", 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < 16; i++) begin
            rst  = vecs[i].rst;
            dinA = vecs[i].din;
            applyStimulus();
            checkA($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rise, vecs[i].fall);
            checkB($sformatf("vec%0d", i));
        end

        // Async reset while dout is high: output drops with no clock edge.
        dinA = 1'b1;
        applyStimulus();
        applyStimulus();
        checkA("settled-high", 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkA("async-reset-entry", 1'b0, 1'b0, 1'b0);
        checkB("async-reset-entry");
        applyStimulus();
        checkA("held-in-reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus();
        checkA("release-edge1", 1'b0, 1'b0, 1'b0);
        applyStimulus();
        checkA("release-edge2", 1'b1, 1'b1, 1'b0);

        // Reset between the two stages discards the in-flight 1.
        dinA = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkA("settled-low", 1'b0, 1'b0, 1'b0);
        dinA = 1'b1;
        applyStimulus();
        checkA("inflight-edge1", 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkA("inflight-reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus();
        checkA("inflight-restart1", 1'b0, 1'b0, 1'b0);
        checkB("inflight-restart1");
        applyStimulus();
        checkA("inflight-restart2", 1'b1, 1'b1, 1'b0);

        // Four-bit, three-stage instance: three edges of latency.
        dinC = 4'b1010;
        applyStimulus();
        checkC("c-up-edge1", 4'b0000, 4'b0000, 4'b0000);
        applyStimulus();
        checkC("c-up-edge2", 4'b0000, 4'b0000, 4'b0000);
        applyStimulus();
        checkC("c-up-edge3", 4'b1010, 4'b1010, 4'b0000);
        applyStimulus();
        checkC("c-up-edge4", 4'b1010, 4'b0000, 4'b0000);
        dinC = 4'b0101;
        applyStimulus();
        checkC("c-swap-edge1", 4'b1010, 4'b0000, 4'b0000);
        applyStimulus();
        checkC("c-swap-edge2", 4'b1010, 4'b0000, 4'b0000);
        applyStimulus();
        checkC("c-swap-edge3", 4'b0101, 4'b0101, 4'b1010);
        applyStimulus();
        checkC("c-swap-edge4", 4'b0101, 4'b0000, 4'b0000);
        checkB("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ff2_sync_n

// File: doc/ff2_sync_n.md
FF2_SYNC_N -- requirements
Module: ff2_sync_n

Interface
REQ-001 The block SHALL have parameter W, default 1, giving the number of independent bits synchronized.
REQ-002 The block SHALL have parameter STAGES, default 2, giving the flip-flop chain depth per bit.
REQ-003 The block SHALL have parameter RESET_VAL, W bits, default all-zero, giving the value loaded into every stage on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: destination clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port din, input, W bits: asynchronous level input from a foreign clock domain.
REQ-007 The block SHALL have port dout, output, W bits: din synchronized to clk.
REQ-008 The block SHALL have port rise, output, W bits: one-cycle pulse per bit on a 0->1 change of dout.
REQ-009 The block SHALL have port fall, output, W bits: one-cycle pulse per bit on a 1->0 change of dout.

Function
REQ-010 Each bit SHALL pass through its own chain of STAGES flops clocked on the rising edge of clk, with no logic between stages.
REQ-011 dout SHALL be the registered output of the last stage, with no combinational path from din.
REQ-012 A din change set up before rising edge k SHALL appear on dout after edge k+STAGES-1: 2 edges at STAGES=2.
REQ-013 Bits SHALL be synchronized independently; multi-bit coherency is not provided, so callers pass single-bit levels or Gray code only.
REQ-014 A din pulse shorter than one clk period MAY be lost, and the block SHALL NOT stretch or capture pulses.
REQ-015 A history flop per bit SHALL hold the previous dout; rise = dout AND NOT history, and fall = NOT dout AND history.
REQ-016 rise and fall SHALL be high for exactly the first clk cycle in which dout shows the new value.
REQ-017 rise and fall SHALL never be high together for the same bit.
REQ-018 A din toggling every cycle SHALL produce dout toggling every cycle, delayed by the latency, with alternating rise/fall pulses.
REQ-019 W<1 or STAGES<2 SHALL cause an elaboration-time error.

Reset
REQ-020 While rst is high, all synchronizer stages and history flops SHALL be held at RESET_VAL immediately, independent of clk.
REQ-021 During reset, dout SHALL equal RESET_VAL and rise/fall SHALL be 0.
REQ-022 After rst deasserts, the first din sample SHALL be taken on the first rising clk edge.
REQ-023 Reset SHALL NOT itself generate a rise or fall pulse, on entry or exit.
REQ-024 Reset asserted mid-propagation SHALL discard in-flight values.

Configuration
REQ-025 Macro FF2_SYNC_N_EDGE_EN SHALL control the edge detector.
REQ-026 With FF2_SYNC_N_EDGE_EN defined, the history flops and rise/fall logic SHALL be built per REQ-015..REQ-017.
REQ-027 Without FF2_SYNC_N_EDGE_EN, the history flops SHALL be omitted, rise and fall SHALL be tied to 0, and the port list SHALL be unchanged.

Structure
REQ-028 A shared package ff2_sync_n_pkg SHALL hold constants SYNC_STAGES_DEFAULT (2) and SYNC_STAGES_MIN (2).
REQ-029 Sub-module ff2_sync_bit SHALL implement one bit's flop chain, with parameters STAGES and RESET_VAL and ports clk, rst, d, q.
REQ-030 ff2_sync_n SHALL instantiate ff2_sync_bit W times via generate, and the edge logic SHALL live in ff2_sync_n.
REQ-031 Synchronizer flops SHALL carry the tool attribute marking them as asynchronous-register/synchronizer.

Verification
REQ-032 W=1, STAGES=2: rst 1->0, din 0->1 before edge 5 -> dout=1 from edge 6 and rise=1 for the cycle after edge 6 only.
REQ-033 W=1: din 1->0 after settling -> fall pulses one cycle and dout=0 two edges later; rise stays 0.
REQ-034 RESET_VAL=1, din=1 through reset release -> dout=1 and no rise/fall pulse at any time.
REQ-035 Set din=1 and assert rst after edge 1, before edge 2 -> dout returns to RESET_VAL asynchronously; after release, propagation restarts with full latency.
REQ-036 W=4, STAGES=3, din 4'b0000->4'b1010 -> dout=4'b1010 three edges later; rise=4'b1010 for one cycle.
REQ-037 Build without FF2_SYNC_N_EDGE_EN, repeating REQ-032 -> identical dout timing and rise=fall=0 throughout.
